// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - oversampled SPI slave with SCLK/CSB/MOSI resynchronised into clk
//
// Optional feature macro: SPI_SLAVE_SYNC_PARITY_EN (each word is followed by an even parity bit)
//
// Ports:
//   clk, rst                        system clock (rising edge), asynchronous active-high reset
//   cfg_enable                      block enable, sampled when CSB falls
//   cfg_lsb_first, cfg_mode         bit order and {CPOL, CPHA}, latched for the whole frame
//   tx_data, tx_valid, tx_ready      next word to transmit; tx_ready pulses when consumed
//   rx_data, rx_valid, rx_ready      received word handshake
//   rx_overrun_it, tx_underrun_it,
//   frame_err_it, par_err_it         single-cycle event pulses
//   busy                            a frame is in progress
//   ms_csb, ms_sclk, ms_mosi         SPI pins from the master (asynchronous)
//   ms_miso, ms_miso_oe              registered MISO and its pad enable
module spi_slave_sync #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE     = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    input  logic                  cfg_lsb_first,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun_it,
    output logic                  tx_underrun_it,
    output logic                  frame_err_it,
    output logic                  par_err_it,
    output logic                  busy,
    input  logic                  ms_csb,
    input  logic                  ms_sclk,
    input  logic                  ms_mosi,
    output logic                  ms_miso,
    output logic                  ms_miso_oe
);

`ifdef SPI_SLAVE_SYNC_PARITY_EN
    localparam int FRAME_BITS = DATA_WIDTH + 1;
`else
    localparam int FRAME_BITS = DATA_WIDTH;
`endif
    localparam int              CW       = $clog2(FRAME_BITS);
    localparam int              IW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(FRAME_BITS - 1);
    // Extra bit so DATA_WIDTH itself is representable when no parity bit widens the counter.
    localparam logic [CW:0]     DW_C     = (CW + 1)'(DATA_WIDTH);

    typedef enum logic {IDLE, XFER} state_t;

    logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, mosi_sync;
    logic                   csb_d, sclk_d, mosi_r;
    logic                   csb_rise, csb_fall, sclk_rise, sclk_fall;

    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic                   cpol_q, cpha_q, lsb_q;
    logic [DATA_WIDTH-1:0]  tx_word, rx_shift, rx_next, load_word;
    logic                   lead_ev, trail_ev, sample_ev, shift_ev;
    logic [IW-1:0]          rx_pos;

    // Edge pulses are registered so they line up with mosi_r, which carries the
    // same synchroniser delay as SCLK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csb_sync  <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            csb_d     <= 1'b1;
            sclk_d    <= 1'b0;
            mosi_r    <= 1'b0;
            csb_rise  <= 1'b0;
            csb_fall  <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], ms_csb};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ms_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], ms_mosi};
            csb_d     <= csb_sync[SYNC_STAGES-1];
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            mosi_r    <= mosi_sync[SYNC_STAGES-1];
            csb_rise  <= csb_sync[SYNC_STAGES-1] & ~csb_d;
            csb_fall  <= ~csb_sync[SYNC_STAGES-1] & csb_d;
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_d;
        end
    end

    // Bit idx of word w in transmit order; idx == DATA_WIDTH is the parity slot.
    function automatic logic send_bit(input logic [DATA_WIDTH-1:0] w,
                                      input logic [CW-1:0]         idx,
                                      input logic                  lsb);
        logic [IW-1:0] pos;
        pos = lsb ? IW'(idx) : IW'(DATA_WIDTH - 1) - IW'(idx);
        if ({1'b0, idx} >= DW_C)
            send_bit = ^w;
        else
            send_bit = w[pos];
    endfunction

    always_comb begin
        lead_ev   = cpol_q ? sclk_fall : sclk_rise;
        trail_ev  = cpol_q ? sclk_rise : sclk_fall;
        sample_ev = cpha_q ? trail_ev : lead_ev;
        shift_ev  = cpha_q ? lead_ev : trail_ev;
        load_word = tx_valid ? tx_data : TX_IDLE;
        // Received bits go straight to their final position, so no reorder at completion.
        rx_pos    = lsb_q ? IW'(bit_cnt) : IW'(DATA_WIDTH - 1) - IW'(bit_cnt);
        rx_next   = rx_shift;
        if ({1'b0, bit_cnt} < DW_C)
            rx_next[rx_pos] = mosi_r;
    end

`ifdef SPI_SLAVE_SYNC_PARITY_EN
    logic par_err_r;
    assign par_err_it = par_err_r;
`else
    assign par_err_it = 1'b0;
`endif

    assign busy = (state == XFER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            cpol_q         <= 1'b0;
            cpha_q         <= 1'b0;
            lsb_q          <= 1'b0;
            tx_word        <= '0;
            rx_shift       <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            ms_miso        <= 1'b0;
            ms_miso_oe     <= 1'b0;
            tx_ready       <= 1'b0;
            tx_underrun_it <= 1'b0;
            rx_overrun_it  <= 1'b0;
            frame_err_it   <= 1'b0;
`ifdef SPI_SLAVE_SYNC_PARITY_EN
            par_err_r      <= 1'b0;
`endif
        end else begin
            tx_ready       <= 1'b0;
            tx_underrun_it <= 1'b0;
            rx_overrun_it  <= 1'b0;
            frame_err_it   <= 1'b0;
`ifdef SPI_SLAVE_SYNC_PARITY_EN
            par_err_r      <= 1'b0;
`endif
            // A completion later in this block overrides the clear.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (csb_fall && cfg_enable) begin
                        state          <= XFER;
                        cpol_q         <= cfg_mode[1];
                        cpha_q         <= cfg_mode[0];
                        lsb_q          <= cfg_lsb_first;
                        bit_cnt        <= '0;
                        tx_word        <= load_word;
                        tx_ready       <= tx_valid;
                        tx_underrun_it <= ~tx_valid;
                        ms_miso_oe     <= 1'b1;
                        // CPHA=0 has no shift edge before the first sample.
                        if (!cfg_mode[0])
                            ms_miso <= send_bit(load_word, '0, cfg_lsb_first);
                    end
                end
                XFER: begin
                    if (csb_rise) begin
                        state        <= IDLE;
                        ms_miso_oe   <= 1'b0;
                        ms_miso      <= 1'b0;
                        bit_cnt      <= '0;
                        frame_err_it <= (bit_cnt != '0);
                    end else if (sample_ev) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt        <= '0;
                            rx_data        <= rx_next;
                            rx_valid       <= 1'b1;
                            rx_overrun_it  <= rx_valid & ~rx_ready;
                            tx_word        <= load_word;
                            tx_ready       <= tx_valid;
                            tx_underrun_it <= ~tx_valid;
`ifdef SPI_SLAVE_SYNC_PARITY_EN
                            // In the parity slot rx_shift already holds the whole data word.
                            par_err_r      <= mosi_r ^ (^rx_shift);
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (shift_ev) begin
                        ms_miso <= send_bit(tx_word, bit_cnt, lsb_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb/tb_spi_slave_sync.sv - scoreboard bench for spi_slave_sync
module tb_spi_slave_sync;
    localparam int              DW     = 8;
    localparam int              SYNC   = 2;
    localparam int              H      = 6;
    localparam logic [DW-1:0]   IDLE_W = '1;
`ifdef SPI_SLAVE_SYNC_PARITY_EN
    localparam int FB = DW + 1;
`else
    localparam int FB = DW;
`endif

    logic          clk, rst;
    logic          cfg_enable, cfg_lsb_first;
    logic [1:0]    cfg_mode;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, rx_ready;
    logic          rx_overrun_it, tx_underrun_it, frame_err_it, par_err_it, busy;
    logic          ms_csb, ms_sclk, ms_mosi, ms_miso, ms_miso_oe;

    spi_slave_sync #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .TX_IDLE(IDLE_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_enable(cfg_enable), .cfg_lsb_first(cfg_lsb_first), .cfg_mode(cfg_mode),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_overrun_it(rx_overrun_it), .tx_underrun_it(tx_underrun_it),
        .frame_err_it(frame_err_it), .par_err_it(par_err_it), .busy(busy),
        .ms_csb(ms_csb), .ms_sclk(ms_sclk), .ms_mosi(ms_mosi),
        .ms_miso(ms_miso), .ms_miso_oe(ms_miso_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            checks = 0;
    int            errors = 0;
    int            n_txr = 0, n_und = 0, n_ovr = 0, n_fe = 0, n_pe = 0;
    int            rx_mode = 0;
    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] mosi_words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // TX source: presents the head of tx_q, drops it when the DUT consumes it.
    initial begin
        tx_valid = 1'b0;
        tx_data  = '0;
        forever begin
            @(negedge clk);
            if (tx_ready && tx_q.size() > 0)
                void'(tx_q.pop_front());
            tx_valid = (tx_q.size() > 0);
            if (tx_valid) tx_data = tx_q[0];
            else          tx_data = '0;
        end
    end

    // RX consumer: 0 = random ready, 1 = held low, 2 = held high.
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rx_mode)
                0:       rx_ready = 1'($urandom_range(0, 1));
                1:       rx_ready = 1'b0;
                default: rx_ready = 1'b1;
            endcase
        end
    end

    // Monitor: counts event pulses and scores every accepted RX word.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                n_txr += int'(tx_ready);
                n_und += int'(tx_underrun_it);
                n_ovr += int'(rx_overrun_it);
                n_fe  += int'(frame_err_it);
                n_pe  += int'(par_err_it);
                if (rx_valid && rx_ready) begin
                    if (exp_rx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no word", rx_data);
                    end else begin
                        check("rx_data", rx_data, exp_rx.pop_front());
                    end
                end
            end
        end
    end

    // SPI master for one CSB frame: nwords full words from mosi_words, then
    // 'partial' extra bits. ovr: consumer is stalled, only the last word survives.
    // exact_idx: pulse rx_ready exactly on that word's completion cycle.
    task automatic spi_frame(input logic [1:0] mode, input bit lsb, input int nwords,
                             input int partial, input bit ovr, input int exact_idx,
                             input bit bad_par);
        logic [DW-1:0] txs[$];
        logic [DW-1:0] w, got, tmp, exp_w;
        int            loads, avail, used, nb, pos;
        int            txr0, und0, ovr0, fe0, pe0;
        logic          b, smp, par_got;
        txs   = tx_q;
        avail = txs.size();
        loads = nwords + 1;
        used  = (loads < avail) ? loads : avail;
        if (!ovr) begin
            foreach (mosi_words[i]) exp_rx.push_back(mosi_words[i]);
        end else if (nwords > 0) begin
            exp_rx.push_back(mosi_words[nwords-1]);
        end
        @(negedge clk);
        cfg_mode      = mode;
        cfg_lsb_first = lsb;
        ms_sclk       = mode[1];
        repeat (H) @(negedge clk);
        txr0 = n_txr; und0 = n_und; ovr0 = n_ovr; fe0 = n_fe; pe0 = n_pe;
        ms_csb = 1'b0;
        for (int j = 0; j < nwords + ((partial > 0) ? 1 : 0); j++) begin
            if (j < nwords) begin w = mosi_words[j]; nb = FB;      end
            else            begin w = DW'($urandom); nb = partial; end
            got = '0;
            par_got = 1'b0;
            for (int k = 0; k < nb; k++) begin
                pos = lsb ? k : DW - 1 - k;
                if (k < DW) begin
                    tmp = w >> pos;
                    b   = tmp[0];
                end else begin
                    b = (^w) ^ bad_par;
                end
                if (!mode[0]) begin
                    ms_mosi = b;
                    #(H*10);
                    ms_sclk = ~ms_sclk;
                    smp = ms_miso;
                    if (j == exact_idx && k == FB - 1)
                        fork begin #((SYNC+1)*10-8); rx_mode = 2; #10; rx_mode = 1; end join_none
                    #(H*10);
                    ms_sclk = ~ms_sclk;
                end else begin
                    #(H*10);
                    ms_sclk = ~ms_sclk;
                    ms_mosi = b;
                    #(H*10);
                    ms_sclk = ~ms_sclk;
                    smp = ms_miso;
                    if (j == exact_idx && k == FB - 1)
                        fork begin #((SYNC+1)*10-8); rx_mode = 2; #10; rx_mode = 1; end join_none
                end
                if (k < DW) got = got | (DW'(smp) << pos);
                else        par_got = smp;
            end
            if (j < nwords) begin
                exp_w = (j < avail) ? txs[j] : IDLE_W;
                check($sformatf("miso_word%0d", j), got, exp_w);
`ifdef SPI_SLAVE_SYNC_PARITY_EN
                check($sformatf("miso_parity%0d", j), par_got, ^exp_w);
`endif
            end
        end
        #(H*10);
        ms_csb = 1'b1;
        #(H*20);
        check("tx_ready_pulses", n_txr - txr0, used);
        check("underrun_pulses", n_und - und0, loads - used);
        check("overrun_pulses", n_ovr - ovr0, (ovr && nwords > 1) ? nwords - 1 : 0);
        check("frame_err_pulses", n_fe - fe0, (partial > 0) ? 1 : 0);
        check("par_err_pulses", n_pe - pe0, (FB > DW && bad_par) ? nwords : 0);
        check("busy_after_frame", busy, 1'b0);
        check("oe_after_frame", ms_miso_oe, 1'b0);
        check("tx_left", tx_q.size(), avail - used);
        tx_q.delete();
        mosi_words.delete();
    endtask

    int nw, ntx;

    initial begin
        rst = 1'b1; ms_csb = 1'b1; ms_sclk = 1'b0; ms_mosi = 1'b0;
        cfg_enable = 1'b1; cfg_lsb_first = 1'b0; cfg_mode = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_rx_data", rx_data, 0);
        check("reset_flags", {ms_miso, ms_miso_oe, busy, tx_ready, rx_valid}, 0);
        check("reset_pulses", {rx_overrun_it, tx_underrun_it, frame_err_it, par_err_it}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Mode 0, MSB first: A5 in, 3C out.
        tx_q.push_back(8'h3C);
        mosi_words.push_back(8'hA5);
        spi_frame(2'b00, 1'b0, 1, 0, 1'b0, -1, 1'b0);

        // Modes 1..3, LSB first, back-to-back 01, 80.
        for (int m = 1; m < 4; m++) begin
            tx_q.push_back(DW'($urandom));
            tx_q.push_back(DW'($urandom));
            mosi_words.push_back(8'h01);
            mosi_words.push_back(8'h80);
            spi_frame(2'(m), 1'b1, 2, 0, 1'b0, -1, 1'b0);
        end

        // No TX data at all: idle word and an underrun per load.
        mosi_words.push_back(DW'($urandom));
        mosi_words.push_back(DW'($urandom));
        spi_frame(2'b01, 1'b0, 2, 0, 1'b0, -1, 1'b0);

        // Stalled consumer: second word overwrites the first.
        rx_mode = 1;
        mosi_words.push_back(8'h5A);
        mosi_words.push_back(8'hC3);
        spi_frame(2'b00, 1'b0, 2, 0, 1'b1, -1, 1'b0);
        rx_mode = 0;
        repeat (20) @(negedge clk);

        // Ready exactly on the second completion: no overrun, both words delivered.
        rx_mode = 1;
        mosi_words.push_back(8'h12);
        mosi_words.push_back(8'hEF);
        spi_frame(2'b11, 1'b0, 2, 0, 1'b0, 1, 1'b0);
        rx_mode = 0;
        repeat (20) @(negedge clk);

        // CSB rises after 5 bits.
        rx_mode = 2;
        repeat (10) @(negedge clk);
        spi_frame(2'b10, 1'b0, 0, 5, 1'b0, -1, 1'b0);
        check("rx_valid_after_frame_err", rx_valid, 1'b0);
        rx_mode = 0;

        // Randomised frames.
        for (int i = 0; i < 6; i++) begin
            nw  = $urandom_range(1, 3);
            ntx = $urandom_range(0, nw + 1);
            for (int t = 0; t < ntx; t++) tx_q.push_back(DW'($urandom));
            for (int t = 0; t < nw; t++) mosi_words.push_back(DW'($urandom));
            spi_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), nw, 0, 1'b0, -1, 1'b0);
        end

`ifdef SPI_SLAVE_SYNC_PARITY_EN
        mosi_words.push_back(8'h03);
        spi_frame(2'b00, 1'b0, 1, 0, 1'b0, -1, 1'b1);
        mosi_words.push_back(8'h03);
        spi_frame(2'b00, 1'b0, 1, 0, 1'b0, -1, 1'b0);
`endif

        // Disabled block ignores CSB.
        rx_mode = 2;
        repeat (20) @(negedge clk);
        nw = n_txr + n_und;
        cfg_enable = 1'b0;
        ms_csb = 1'b0;
        repeat (20) @(negedge clk);
        check("disabled_busy", {busy, ms_miso_oe}, 0);
        check("disabled_loads", n_txr + n_und - nw, 0);
        ms_csb = 1'b1;
        repeat (10) @(negedge clk);
        cfg_enable = 1'b1;

        // Reset in the middle of a frame with an unread word pending.
        rx_mode = 1;
        mosi_words.push_back(8'h77);
        spi_frame(2'b00, 1'b0, 1, 0, 1'b0, -1, 1'b0);
        void'(exp_rx.pop_back());
        check("rx_valid_before_reset", rx_valid, 1'b1);
        ms_csb = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_mid_frame", {busy, ms_miso_oe}, 2'b11);
        #3;
        rst = 1'b1;
        #1;
        check("midreset_rx_data", rx_data, 0);
        check("midreset_flags", {ms_miso, ms_miso_oe, busy, tx_ready, rx_valid}, 0);
        check("midreset_pulses", {rx_overrun_it, tx_underrun_it, frame_err_it, par_err_it}, 0);
        ms_csb = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        rx_mode = 2;
        repeat (20) @(negedge clk);
        check("rx_words_outstanding", exp_rx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete, expected completion before limit");
        $fatal(1);
    end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Fully synchronous, oversampled SPI slave: SCLK, CSB and MOSI are resynchronised into the system clock, so the block has no derived or gated clocks. Supports all four SPI modes, MSB- or LSB-first, and a parametrised word width. Sits between the SPI pads and the register or DMA layer, with valid/ready handshakes on both data directions. Successor of the SPI-clocked slave.

## Interface
- `DATA_WIDTH`, 8: bits per word, at least 2.
- `SYNC_STAGES`, 2: synchroniser depth on `ms_csb`/`ms_sclk`/`ms_mosi`, at least 2.
- `TX_IDLE`, all ones: word shifted out when no TX data is available.
- Clock and reset (decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_enable` in 1: block enable; when 0 the block ignores CSB and stays IDLE.
- `cfg_lsb_first` in 1: 1 = LSB first, 0 = MSB first.
- `cfg_mode` in 2: `[1]` = CPOL, `[0]` = CPHA.
- `tx_data` in DATA_WIDTH: next word to transmit.
- `tx_valid` in 1: `tx_data` is available.
- `tx_ready` out 1: one-cycle pulse when `tx_data` is consumed.
- `rx_data` out DATA_WIDTH: received word.
- `rx_valid` out 1: `rx_data` holds an unread word.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `rx_overrun_it` out 1: pulse; an unread word was overwritten.
- `tx_underrun_it` out 1: pulse; `TX_IDLE` was loaded.
- `frame_err_it` out 1: pulse; CSB rose mid-word.
- `par_err_it` out 1: pulse; parity mismatch (see Configuration).
- `busy` out 1: the FSM is not IDLE.
- `ms_csb` in 1: chip select, active low, asynchronous.
- `ms_sclk` in 1: SPI clock, asynchronous.
- `ms_mosi` in 1: master out, slave in.
- `ms_miso` out 1: slave out, master in.
- `ms_miso_oe` out 1: pad output enable, high while selected.

## Operation
- **Synchronisers and edge detection**
  - Each pin passes through `SYNC_STAGES` flops. One extra flop on SCLK and CSB gives rise/fall detection.
  - Leading edge = rising if CPOL=0. Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- **FSM states:** IDLE, XFER.
  - IDLE → XFER on synchronised CSB fall while `cfg_enable`=1. In the same cycle: `cfg_mode`/`cfg_lsb_first` are latched for the whole frame, bit counter is set to 0, and the first TX word is loaded.
  - XFER → IDLE on synchronised CSB rise. SCLK edges are ignored in IDLE.
- **Word load** (at CSB fall and at every word completion)
  - If `tx_valid`=1: take `tx_data` and pulse `tx_ready`.
  - Otherwise: take `TX_IDLE` and pulse `tx_underrun_it`.
- **MISO driving**
  - `ms_miso` is a registered output.
  - CPHA=0: the first bit is presented at the load performed on CSB fall.
  - Otherwise, each shift edge presents the next unsent bit. After a word completes, the next shift edge presents bit 0 of the newly loaded word.
  - Bit order follows the latched `cfg_lsb_first`.
- **Receive**
  - Each sample edge shifts in MOSI and increments the bit counter.
  - At the last bit the counter wraps to 0, `rx_data` is updated (reordered per `cfg_lsb_first`), `rx_valid` is set and the next word is loaded.
- **RX handshake**
  - `rx_valid` clears on `rx_valid & rx_ready`.
  - Completion while `rx_valid`=1 and `rx_ready`=0: the new word overwrites `rx_data`, `rx_valid` stays 1, `rx_overrun_it` pulses.
  - Completion in the same cycle as `rx_ready`=1: no overrun; `rx_valid` stays 1 with the new word.
- **Frame error:** CSB rise with bit counter ≠ 0 pulses `frame_err_it`; partial bits are discarded. CSB rise with counter = 0 is a clean end.
- **Enable:** `cfg_enable` falling during XFER takes effect at the next CSB rise.
- **Reset values:** `ms_miso`=0, `ms_miso_oe`=0, `rx_data`=0, `busy`=0, `tx_ready`=0, `rx_valid`=0, all `*_it`=0. Reset mid-frame aborts with no pulses.

## Timing
- Pin edge to internal edge event: `SYNC_STAGES`+1 clk cycles.
- Last sample pin edge to `rx_valid`=1: `SYNC_STAGES`+2 cycles.
- Shift pin edge to `ms_miso` update: `SYNC_STAGES`+2 cycles.
- CSB pin fall to `ms_miso_oe`=1 and `tx_ready`: `SYNC_STAGES`+2 cycles.
- Required: each SCLK half-period ≥ (`SYNC_STAGES`+3) clk periods. Defaults therefore need fclk ≥ 10·fsclk.
- CSB setup to first SCLK edge: same minimum.
- All `*_it` outputs are single-cycle pulses in `clk`.

## Configuration
- Macro: `SPI_SLAVE_SYNC_PARITY_EN`.
- **Defined:**
  - Frame is `DATA_WIDTH`+1 bits; the final bit is even parity over the data.
  - The slave sends parity of the loaded TX word after its last data bit.
  - A received parity mismatch pulses `par_err_it` in the cycle `rx_valid` is set; the word is still delivered.
- **Undefined:** frame is `DATA_WIDTH` bits and `par_err_it` is tied 0. The port is always present.

## Test plan
- Mode 0, MSB first, master sends 0xA5 with `tx_data`=0x3C valid → `rx_data`=0xA5, `rx_valid`=1; master receives 0x3C; one `tx_ready` pulse at CSB fall.
- Modes 1, 2, 3 with LSB first, back-to-back 0x01, 0x80 in one CSB frame → `rx_data` sequence 0x01 then 0x80; MISO bit 0 of the second word appears on the first shift edge after completion.
- `tx_valid`=0 at load → MISO shifts 0xFF and `tx_underrun_it` pulses once per word.
- Two words received with `rx_ready` held 0 → `rx_data`=second word, one `rx_overrun_it` pulse. Repeat with `rx_ready`=1 exactly on the completion cycle → no overrun.
- CSB raised after 5 bits → `frame_err_it` pulse, `rx_valid` stays 0, `busy` returns to 0. `rst` asserted mid-frame → all outputs at reset values immediately.
- With `SPI_SLAVE_SYNC_PARITY_EN`: master sends 0x03 with parity bit 1 → `par_err_it` pulse with `rx_data`=0x03. With parity bit 0 → no pulse.
